// File: rtl/rf_stream_loader_pkg.sv
// rf_stream_loader_pkg: shared register-file sizing and loader FSM state type.
package rf_stream_loader_pkg;
    localparam int phit_size    = 64;
    localparam int dwidth_RFadd = 4;
    localparam int depth_RF     = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } rf_ld_state_t;
endpackage

// File: rtl/rf_stream_loader_if.sv
// rf_stream_loader_if: control, phit stream and register-file write port of the loader.
interface rf_stream_loader_if
    import rf_stream_loader_pkg::*;
#(
    parameter int PHIT = phit_size,
    parameter int AW   = dwidth_RFadd
);
    logic            start;
    logic [AW-1:0]   base_addr;
    logic [AW:0]     len;
    logic [PHIT-1:0] s_data;
    logic            s_valid;
    logic            s_last;
    logic            s_ready;
    logic [PHIT-1:0] rf_d_in;
    logic [AW-1:0]   rf_wr_addr;
    logic            rf_wen;
    logic            busy;
    logic            done;
    logic            err;
    logic [AW:0]     count;

    modport slave (
        input  start, base_addr, len, s_data, s_valid, s_last,
        output s_ready, rf_d_in, rf_wr_addr, rf_wen, busy, done, err, count
    );
    modport master (
        output start, base_addr, len, s_data, s_valid, s_last,
        input  s_ready, rf_d_in, rf_wr_addr, rf_wen, busy, done, err, count
    );
endinterface

// File: rtl/rf_addr_wrap.sv
// rf_addr_wrap: loadable register-file pointer that increments and wraps to 0 after DEPTH-1.
module rf_addr_wrap
    import rf_stream_loader_pkg::*;
#(
    parameter int AW    = dwidth_RFadd,
    parameter int DEPTH = depth_RF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [AW-1:0] load_val_i,
    input  logic          inc_i,
    output logic [AW-1:0] ptr_o
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    logic [AW-1:0] ptr_q, ptr_d;
    always_comb ptr_d = load_i ? load_val_i : inc_i ? (ptr_q == LAST ? '0 : ptr_q + 1'b1) : ptr_q;
    always_ff @(posedge clk) ptr_q <= rst ? '0 : ptr_d;
    assign ptr_o = ptr_q;
endmodule

// File: rtl/rf_stream_loader.sv
// rf_stream_loader: writes an accepted phit stream into consecutive register-file entries
// from a programmed base, wrapping at DEPTH, and pulses done/err when the load ends.
module rf_stream_loader
    import rf_stream_loader_pkg::*;
#(
    parameter int PHIT  = phit_size,
    parameter int AW    = dwidth_RFadd,
    parameter int DEPTH = depth_RF
) (
    input logic               clk,
    input logic               rst,
    rf_stream_loader_if.slave bus
);
    rf_ld_state_t    state_q;
    logic [AW:0]     len_q, count_q, count_d;
    logic [AW-1:0]   addr_q, ptr;
    logic [PHIT-1:0] data_q;
    logic            wen_q, err_q, accept, final_beat, len_ok, ptr_load;

    assign accept     = state_q == LOAD && bus.s_valid;
    assign count_d    = count_q + 1'b1;
    assign final_beat = count_d == len_q;
    assign len_ok     = bus.len != '0 && bus.len <= (AW+1)'(DEPTH);
    assign ptr_load   = state_q == IDLE && bus.start && len_ok;

    rf_addr_wrap #(.AW(AW), .DEPTH(DEPTH)) u_ptr (
        .clk       (clk),
        .rst       (rst),
        .load_i    (ptr_load),
        .load_val_i(bus.base_addr),
        .inc_i     (accept),
        .ptr_o     (ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            count_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            wen_q <= accept;
            if (accept) begin
                addr_q  <= ptr;
                data_q  <= bus.s_data;
                count_q <= count_d;
            end
            case (state_q)
                IDLE: if (bus.start) begin
                    state_q <= len_ok ? LOAD : DONE;
                    err_q   <= !len_ok;
                    if (len_ok) begin
                        len_q   <= bus.len;
                        count_q <= '0;
                    end
                end
                // A truncating s_last ends the load just like the final beat, but flags an error.
                LOAD: if (accept && (final_beat || bus.s_last)) begin
                    state_q <= DONE;
                    err_q   <= !(final_beat && bus.s_last);
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.s_ready    = state_q == LOAD;
    assign bus.busy       = state_q != IDLE;
    assign bus.done       = state_q == DONE;
    assign bus.err        = state_q == DONE && err_q;
    assign bus.rf_wen     = wen_q;
    assign bus.rf_wr_addr = addr_q;
    assign bus.rf_d_in    = data_q;
    assign bus.count      = count_q;
endmodule
